// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM encoding and
// the helper that turns a byte offset and size into a lane bit position.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAULT,
        ST_LOAD,
        ST_RMW_RD,
        ST_STORE,
        ST_RESP
    } state_t;

    // Bit position of the addressed lane inside the little-endian word.
    function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo,
                                              input logic [1:0] size);
        case (size)
            SIZE_BYTE: return {addr_lo, 3'b000};
            SIZE_HALF: return {addr_lo[1], 4'b0000};
            default:   return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data from a word, and
// merges sub-word store data into an existing word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load_value,
    output logic [31:0] o_merged_word
);

    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;

    assign w_shift = lane_shift(i_addr_lo, i_size);
    assign w_byte  = 8'(i_load_word >> w_shift);
    assign w_half  = 16'(i_load_word >> w_shift);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_load_value = i_load_word;
        w_mask       = 32'hFFFF_FFFF;
        case (i_size)
            SIZE_BYTE: begin
                o_load_value = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                w_mask       = 32'h0000_00FF << w_shift;
            end
            SIZE_HALF: begin
                o_load_value = {{16{w_half[15] & ~i_unsigned}}, w_half};
                w_mask       = 32'h0000_FFFF << w_shift;
            end
            default: ;
        endcase
    end

    // A word store uses an all-ones mask, so the merge degenerates to i_wdata.
    assign o_merged_word = (i_old_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-only data memory; sub-word
// stores run as read-modify-write, faults complete without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;

    state_t      r_state, w_next_state;
    logic [31:0] r_addr, r_wdata, r_word, r_resp_rdata;
    logic [1:0]  r_size;
    logic        r_unsigned, r_resp_error;
    logic        w_accept, w_fault, w_bad_align, w_out_of_range;
    logic [31:0] w_load_value, w_merged;

    always_comb begin
        case (req_size)
            SIZE_HALF: w_bad_align = req_address[0];
            SIZE_WORD: w_bad_align = |req_address[1:0];
            SIZE_RSVD: w_bad_align = 1'b1;
            default:   w_bad_align = 1'b0;
        endcase
    end

    assign w_out_of_range = CHECK_RANGE && ({1'b0, req_address} >= BYTE_LIMIT);
    assign w_fault        = w_bad_align || w_out_of_range;
    assign w_accept       = req_valid && req_ready;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_fault)                w_next_state = ST_FAULT;
                    else if (!req_write)        w_next_state = ST_LOAD;
                    else if (req_size == SIZE_WORD) w_next_state = ST_STORE;
                    else                        w_next_state = ST_RMW_RD;
                end
            end
            ST_LOAD:   w_next_state = ST_RESP;
            ST_RMW_RD: w_next_state = ST_STORE;
            ST_STORE:  w_next_state = ST_RESP;
            ST_FAULT:  w_next_state = ST_RESP;
            ST_RESP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Reset gates the memory strobes combinationally so a reset in the
    // write cycle of a read-modify-write cancels that write.
    always_comb begin
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        if (!reset) begin
            req_ready  = (r_state == ST_IDLE);
            mem_read   = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
            mem_write  = (r_state == ST_STORE);
            resp_valid = (r_state == ST_RESP);
        end
    end

    // NOTE: the request and RMW datapath registers have no reset; nothing reads them before an accept loads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr     <= req_address;
            r_size     <= req_size;
            r_wdata    <= req_wdata;
            r_unsigned <= req_unsigned;
        end
        if (r_state == ST_RMW_RD) r_word <= mem_read_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_resp_rdata <= w_load_value;
                    r_resp_error <= 1'b0;
                end
                ST_STORE: begin
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b0;
                end
                ST_FAULT: begin
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    lsu_byte_lane u_lane (
        .i_load_word   (mem_read_data),
        .i_old_word    (r_word),
        .i_wdata       (r_wdata),
        .i_addr_lo     (r_addr[1:0]),
        .i_size        (r_size),
        .i_unsigned    (r_unsigned),
        .o_load_value  (w_load_value),
        .o_merged_word (w_merged)
    );

    assign mem_address    = {r_addr[31:2], 2'b00};
    assign mem_write_data = w_merged;
    assign resp_rdata     = r_resp_rdata;
    assign resp_error     = r_resp_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a 256x32 memory model, a response
// scoreboard with expected cycle numbers, and a monitor on every memory cycle.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_wdata, resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        resp_valid, resp_error, mem_read, mem_write;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_address(req_address), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    logic [31:0] mem [256];
    logic        mem_clear;
    assign mem_read_data = mem_read ? mem[mem_address[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_clear) for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        else if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    end

    typedef struct { logic [31:0] rdata; logic error; int cyc; } exp_t;
    exp_t        sb_q[$];
    exp_t        e;
    int          cyc = 0, n_vec = 0, n_bad = 0;
    int          rd_cnt, wr_cnt, rd_cyc, wr_cyc, last_acc;
    logic [31:0] wr_addr, wr_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            n_vec++;
            if ((mem_read && mem_write) || mem_address[1:0] !== 2'b00 || mem_address >= 32'd1024) begin
                n_bad++;
                $display("FAIL mem_cycle: rd=%b wr=%b addr=%h, required exclusive strobes and aligned in-range addr",
                         mem_read, mem_write, mem_address);
            end
        end
        if (mem_read) begin rd_cnt++; rd_cyc = cyc; end
        if (mem_write) begin wr_cnt++; wr_cyc = cyc; wr_addr = mem_address; wr_data = mem_write_data; end
        if (resp_valid) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: got resp rdata=%h err=%b at cyc %0d, required no response",
                         resp_rdata, resp_error, cyc);
            end else begin
                e = sb_q.pop_front();
                if (resp_rdata !== e.rdata || resp_error !== e.error || cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             resp_rdata, resp_error, cyc, e.rdata, e.error, e.cyc);
                end
            end
        end
    end

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1;
    endtask

    // Presents a request and waits (bounded) for acceptance; the expected
    // response is pushed with its cycle number N + lat. req_valid stays high.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int lat);
        int waited = 0;
        req_write = wr; req_size = sz; req_unsigned = uns; req_address = addr; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && waited < 16) begin @(posedge clk); #1; waited++; end
        if (!req_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, waited);
            req_valid = 1'b0;
            return;
        end
        sb_q.push_back('{rdata: exp_rd, error: exp_err, cyc: cyc + lat});
        last_acc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (sb_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        if (sb_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({req_ready, resp_valid, mem_read, mem_write, resp_error} !== 5'b0 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b rv=%b rd=%b wr=%b err=%b rdata=%h, required all 0",
                     req_ready, resp_valid, mem_read, mem_write, resp_error, resp_rdata);
        end
        reset = 1'b0; #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
    endtask

    task automatic test_word();
        int n0;
        clear_counts();
        issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2); n0 = last_acc;
        drain();
        n_vec++;
        if (wr_cnt !== 1 || rd_cnt !== 0 || wr_cyc !== n0 + 1 || wr_data !== 32'h1234_5678 || mem[4] !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL sw_mem: wr=%0d rd=%0d wcyc=%0d data=%h mem=%h, required 1 0 %0d 12345678 12345678",
                     wr_cnt, rd_cnt, wr_cyc, wr_data, mem[4], n0 + 1);
        end
        clear_counts();
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 2);
        drain();
        n_vec++;
        if (rd_cnt !== 1 || wr_cnt !== 0) begin
            n_bad++; $display("FAIL lw_mem: rd=%0d wr=%0d, required 1 0", rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_subword();
        int n0;
        clear_counts();
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0, 1'b0, 3); n0 = last_acc;
        drain();
        n_vec++;
        if (rd_cnt !== 1 || wr_cnt !== 1 || rd_cyc !== n0 + 1 || wr_cyc !== n0 + 2 ||
            wr_addr !== 32'h10 || mem[4] !== 32'h1234_AB78) begin
            n_bad++;
            $display("FAIL sb_rmw: rd=%0d@%0d wr=%0d@%0d addr=%h mem=%h, required 1@%0d 1@%0d 00000010 1234ab78",
                     rd_cnt, rd_cyc, wr_cnt, wr_cyc, wr_addr, mem[4], n0 + 1, n0 + 2);
        end
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0, 2);
        issue(1'b0, SIZE_BYTE, 1'b1, 32'h11, 32'h0, 32'h0000_00AB, 1'b0, 2);
        drain();
        issue(1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h7777_8001, 32'h0, 1'b0, 3);
        drain();
        n_vec++;
        if (mem[4] !== 32'h8001_AB78) begin
            n_bad++; $display("FAIL sh_merge: mem=%h, required 8001ab78", mem[4]);
        end
        issue(1'b0, SIZE_HALF, 1'b0, 32'h12, 32'h0, 32'hFFFF_8001, 1'b0, 2);
        issue(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0, 2);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h10, 32'h0, 32'h0000_0078, 1'b0, 2);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h3FF, 32'h0, 32'h0, 1'b0, 2);
        drain();
    endtask

    task automatic test_faults();
        logic        f_wr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  f_sz [5] = '{SIZE_HALF, SIZE_WORD, SIZE_RSVD, SIZE_WORD, SIZE_BYTE};
        logic [31:0] f_ad [5] = '{32'h13, 32'h0E, 32'h10, 32'h400, 32'h400};
        for (int i = 0; i < 5; i++) begin
            clear_counts();
            issue(f_wr[i], f_sz[i], 1'b0, f_ad[i], 32'hDEAD_BEEF, 32'h0, 1'b1, 2);
            drain();
            n_vec++;
            if (rd_cnt !== 0 || wr_cnt !== 0) begin
                n_bad++; $display("FAIL fault_%0d_mem: rd=%0d wr=%0d, required 0 0", i, rd_cnt, wr_cnt);
            end
        end
        n_vec++;
        if (mem[4] !== 32'h8001_AB78) begin
            n_bad++; $display("FAIL fault_mem_intact: mem=%h, required 8001ab78", mem[4]);
        end
    endtask

    task automatic test_reset_mid_rmw();
        issue(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
        drain();
        req_write = 1'b1; req_size = SIZE_BYTE; req_address = 32'h20; req_wdata = 32'h11; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (mem_write !== 1'b1) begin
            n_bad++; $display("FAIL rmw_store_cycle: mem_write=%b, required 1", mem_write);
        end
        reset = 1'b1; #1;
        n_vec++;
        if (mem_write !== 1'b0) begin
            n_bad++; $display("FAIL reset_gates_write: mem_write=%b, required 0", mem_write);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({req_ready, resp_valid, mem_read, mem_write, resp_error} !== 5'b0 || resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_rmw_outputs: rdy=%b rv=%b rd=%b wr=%b err=%b rdata=%h, required all 0",
                     req_ready, resp_valid, mem_read, mem_write, resp_error, resp_rdata);
        end
        reset = 1'b0; #1;
        n_vec++;
        if (req_ready !== 1'b1 || mem[8] !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL reset_mid_rmw_state: rdy=%b mem=%h, required 1 cafef00d", req_ready, mem[8]);
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h8001_AB78, 1'b0, 2); a0 = last_acc;
        issue(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 2); a1 = last_acc;
        issue(1'b0, SIZE_WORD, 1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0, 2); a2 = last_acc;
        drain();
        n_vec++;
        if (a1 - a0 !== 3 || a2 - a1 !== 3) begin
            n_bad++; $display("FAIL b2b_spacing: gaps %0d %0d, required 3 3", a1 - a0, a2 - a1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_clear = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = SIZE_WORD; req_unsigned = 1'b0; req_address = '0; req_wdata = '0;
        clear_counts();
        @(posedge clk); #1; mem_clear = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_faults();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
